// File: rtl/lfsr6_pkg.sv
// rtl/lfsr6_pkg.sv - shared constants and types for the 56-bit, 10-bit-per-step LFSR
package lfsr6_pkg;

    localparam int WIDTH = 56;
    localparam int STEPS = 10;
    localparam int CNT_W = 16;

    // Feedback taps above bit 0 (x^5, x^20, x^28, x^38, x^45); bit 0 always takes msb^d
    localparam logic [WIDTH-1:0] TAP_MASK = 56'h00204010100020;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCUM    = 2'd1;
    localparam logic [1:0] ST_WAIT_SIG = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ACCUM    = ST_ACCUM,
        WAIT_SIG = ST_WAIT_SIG
    } fsm_state_t;

    function automatic logic [WIDTH-1:0] lfsr_step1(input logic [WIDTH-1:0] s, input logic d);
        logic [WIDTH-1:0] n;
        logic             msb;
        msb  = s[WIDTH-1];
        n[0] = msb ^ d;
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = TAP_MASK[i] ? (s[i-1] ^ msb) : s[i-1];
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_6_check_if.sv
// rtl/lfsr_6_check_if.sv - word, signature and result handshake bundle for lfsr_6_check
interface lfsr_6_check_if;
    import lfsr6_pkg::*;

    logic [STEPS-1:0] serial_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] sig_in;
    logic             sig_valid;
    logic             sig_ready;
    logic             result_valid;
    logic             result_ok;

    modport master (
        output serial_in, in_valid, in_last, sig_in, sig_valid,
        input  in_ready, sig_ready, result_valid, result_ok
    );

    modport slave (
        input  serial_in, in_valid, in_last, sig_in, sig_valid,
        output in_ready, sig_ready, result_valid, result_ok
    );

endinterface

// File: rtl/lfsr6_step.sv
// rtl/lfsr6_step.sv - combinational 10-bit advance of the 56-bit LFSR, bit 0 of word applied first
module lfsr6_step
    import lfsr6_pkg::*;
(
    input  logic [WIDTH-1:0] state,
    input  logic [STEPS-1:0] word,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = state;
        for (int i = 0; i < STEPS; i++) begin
            next = lfsr_step1(next, word[i]);
        end
    end

endmodule

// File: rtl/lfsr_6_check.sv
// rtl/lfsr_6_check.sv - receive-side LFSR signature checker: accumulate a frame, compare signature
module lfsr_6_check
    import lfsr6_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_load,
    output logic [WIDTH-1:0]  data_out,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    lfsr_6_check_if.slave     link
);

    logic [1:0]        fsm;
    logic [WIDTH-1:0]  state;
    logic [WIDTH-1:0]  state_next;
    logic [CNT_W-1:0]  cnt;
    logic              res_valid;
    logic              res_ok;

    lfsr6_step u_step (
        .state (state),
        .word  (link.serial_in),
        .next  (state_next)
    );

    // start wins over any accept in the same cycle, so it is tested before the FSM case
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            state     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (start) begin
                state <= data_load;
                cnt   <= '0;
                fsm   <= ST_ACCUM;
            end else begin
                case (fsm)
                    ST_ACCUM: begin
                        if (link.in_valid) begin
                            state <= state_next;
                            if (cnt != {CNT_W{1'b1}}) begin
                                cnt <= cnt + 1'b1;
                            end
                            if (link.in_last) begin
                                fsm <= ST_WAIT_SIG;
                            end
                        end
                    end
                    ST_WAIT_SIG: begin
                        if (link.sig_valid) begin
                            res_ok    <= (link.sig_in == state);
                            res_valid <= 1'b1;
                            fsm       <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign link.in_ready     = (fsm == ST_ACCUM);
    assign link.sig_ready    = (fsm == ST_WAIT_SIG);
    assign link.result_valid = res_valid;
    assign link.result_ok    = res_ok;
    assign data_out          = state;
    assign word_count        = cnt;
    assign busy              = (fsm != ST_IDLE);

endmodule

// File: tb/tb_lfsr_6_check.sv
// tb/tb_lfsr_6_check.sv - directed self-checking bench for lfsr_6_check
module tb_lfsr_6_check;

    localparam logic [55:0] POLY = (56'd1 << 45) | (56'd1 << 38) | (56'd1 << 28)
                                 | (56'd1 << 20) | (56'd1 << 5)  | 56'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [55:0] data_load;
    logic [55:0] data_out;
    logic [15:0] word_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lfsr_6_check_if link ();

    lfsr_6_check dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_load  (data_load),
        .data_out   (data_out),
        .word_count (word_count),
        .busy       (busy),
        .link       (link.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] ref_step(input logic [55:0] s, input logic [9:0] w);
        logic msb;
        for (int i = 0; i < 10; i++) begin
            msb = s[55];
            s   = {s[54:0], w[i]} ^ (msb ? POLY : 56'd0);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [55:0] seed);
        start     = 1'b1;
        data_load = seed;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input logic last);
        link.serial_in = w;
        link.in_valid  = 1'b1;
        link.in_last   = last;
        tick();
        link.in_valid  = 1'b0;
        link.in_last   = 1'b0;
    endtask

    task automatic send_sig(input logic [55:0] s);
        link.sig_in    = s;
        link.sig_valid = 1'b1;
        tick();
        link.sig_valid = 1'b0;
    endtask

    logic [55:0] model;
    logic [55:0] seed_b;
    logic [9:0]  w;
    int          acc;
    int          cyc;
    logic        took;

    initial begin
        rst = 1'b1; start = 1'b0; data_load = '0;
        link.serial_in = '0; link.in_valid = 1'b0; link.in_last = 1'b0;
        link.sig_in = '0; link.sig_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_data_out", data_out, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_result_valid", link.result_valid, 0);
        chk("rst_result_ok", link.result_ok, 0);
        chk("rst_in_ready", link.in_ready, 0);
        chk("rst_sig_ready", link.sig_ready, 0);
        chk("rst_busy", busy, 0);

        // seed 0, single word 10'h001
        start_frame(56'd0);
        chk("t1_in_ready", link.in_ready, 1);
        chk("t1_busy", busy, 1);
        send_word(10'h001, 1'b1);
        chk("t1_data_out", data_out, 56'h200);
        chk("t1_word_count", word_count, 1);
        chk("t1_sig_ready", link.sig_ready, 1);
        chk("t1_in_ready_low", link.in_ready, 0);
        chk("t1_no_result_yet", link.result_valid, 0);
        send_sig(56'h200);
        chk("t1_result_valid", link.result_valid, 1);
        chk("t1_result_ok", link.result_ok, 1);
        chk("t1_idle", busy, 0);
        tick();
        chk("t1_pulse_end", link.result_valid, 0);
        chk("t1_ok_held", link.result_ok, 1);
        chk("t1_data_held", data_out, 56'h200);

        // msb-only seed: taps fire once then shift nine places
        start_frame(56'h80000000000000);
        send_word(10'h000, 1'b1);
        chk("t2_data_out", data_out, 56'h40802020004200);
        send_sig(56'h40802020004200);
        chk("t2_result_valid", link.result_valid, 1);
        chk("t2_result_ok", link.result_ok, 1);
        start_frame(56'h80000000000000);
        send_word(10'h000, 1'b1);
        send_sig(56'h40802020004201);
        chk("t2_bad_valid", link.result_valid, 1);
        chk("t2_bad_ok", link.result_ok, 0);

        // 1000-word random frame with input gaps
        model = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
        start_frame(model);
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 5000) begin
            w              = 10'($urandom);
            link.serial_in = w;
            link.in_valid  = ($urandom_range(3) != 0);
            link.in_last   = (acc == 999);
            took           = link.in_valid && link.in_ready;
            tick();
            if (took) begin
                model = ref_step(model, w);
                acc++;
            end
            cyc++;
        end
        link.in_valid = 1'b0; link.in_last = 1'b0;
        chk("t3_words_sent", acc, 1000);
        chk("t3_word_count", word_count, 1000);
        chk("t3_data_out", data_out, model);
        chk("t3_sig_ready", link.sig_ready, 1);
        for (int i = 0; i < 3; i++) begin
            link.sig_in    = {$urandom, $urandom};
            link.sig_valid = 1'b0;
            link.serial_in = 10'($urandom);
            link.in_valid  = 1'b1;
            tick();
            chk("t3_gap_no_result", link.result_valid, 0);
            chk("t3_wait_ignores_word", data_out, model);
            chk("t3_wait_count", word_count, 1000);
        end
        link.in_valid = 1'b0;
        send_sig(model);
        chk("t3_result_valid", link.result_valid, 1);
        chk("t3_result_ok", link.result_ok, 1);

        // start mid-frame with a simultaneous word
        model = 56'h0123456789ABCD;
        start_frame(model);
        for (int i = 0; i < 5; i++) begin
            w = 10'(i * 37 + 5);
            send_word(w, 1'b0);
            model = ref_step(model, w);
        end
        chk("t4_five_words", word_count, 5);
        chk("t4_before_abort", data_out, model);
        seed_b         = 56'hFEDCBA98765432;
        start          = 1'b1;
        data_load      = seed_b;
        link.serial_in = 10'h3FF;
        link.in_valid  = 1'b1;
        link.in_last   = 1'b1;
        tick();
        start = 1'b0; link.in_valid = 1'b0; link.in_last = 1'b0;
        chk("t4_reseed", data_out, seed_b);
        chk("t4_count_clear", word_count, 0);
        chk("t4_no_result", link.result_valid, 0);
        chk("t4_still_accum", link.in_ready, 1);
        send_word(10'h155, 1'b1);
        model = ref_step(seed_b, 10'h155);
        send_sig(model);
        chk("t4_result_ok", link.result_ok, 1);

        // reset while a signature is being offered
        start_frame(56'h00000000ABCDEF);
        send_word(10'h2A5, 1'b1);
        model          = ref_step(56'h00000000ABCDEF, 10'h2A5);
        link.sig_in    = model;
        link.sig_valid = 1'b1;
        rst            = 1'b1;
        tick();
        rst = 1'b0; link.sig_valid = 1'b0;
        chk("t5_data_out", data_out, 0);
        chk("t5_word_count", word_count, 0);
        chk("t5_result_valid", link.result_valid, 0);
        chk("t5_result_ok", link.result_ok, 0);
        chk("t5_in_ready", link.in_ready, 0);
        chk("t5_sig_ready", link.sig_ready, 0);
        chk("t5_busy", busy, 0);
        tick();
        chk("t5_no_late_result", link.result_valid, 0);
        model = 56'h5A5A5A5A5A5A5A;
        start_frame(model);
        send_word(10'h0F0, 1'b0);
        model = ref_step(model, 10'h0F0);
        send_word(10'h30C, 1'b1);
        model = ref_step(model, 10'h30C);
        send_sig(model);
        chk("t5_after_valid", link.result_valid, 1);
        chk("t5_after_ok", link.result_ok, 1);

        // signature offered in IDLE is ignored
        send_sig(model ^ 56'd1);
        chk("t6_idle_no_result", link.result_valid, 0);
        chk("t6_idle_data", data_out, model);
        chk("t6_idle_count", word_count, 2);
        chk("t6_idle_busy", busy, 0);
        chk("t6_ok_held", link.result_ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
